// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage state encoding and the bubble instruction.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;  // addi x0, x0, 0
  localparam int          RD_W             = 5;
  localparam int          INST_W           = 32;

  // The state encoding doubles as the held-entry count.
  function automatic logic [1:0] occupancy_of(input stage_state_e s);
    return s;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One payload slot of the pipeline stage: load-enabled register with async clear.
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: the payload is cleared on reset so no fragment of an in-flight
  // transfer survives it; non-blocking assignment keeps the register race-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional one-entry skid buffer,
// bubble insertion on empty output and synchronous flush.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int          CTRL_W   = 6,
  parameter int          DATA_W   = 32,
  parameter int          NWORDS   = 5,
  parameter bit          SKID_EN  = 1'b1,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [NWORDS*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]          in_rd,
  input  logic                     in_zero,
  input  logic [INST_W-1:0]        in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [NWORDS*DATA_W-1:0] out_data,
  output logic [RD_W-1:0]          out_rd,
  output logic                     out_zero,
  output logic [INST_W-1:0]        out_inst,
  input  logic                     flush,
  output logic [1:0]               occupancy
);

  localparam int PAY_W = CTRL_W + NWORDS*DATA_W + RD_W + 1 + INST_W;

  stage_state_e state, state_nxt;
  logic         in_ready_q;
  logic         in_fire, out_fire;
  logic         load_main, load_skid;

  logic [PAY_W-1:0] in_pay, main_d, main_pay, skid_pay;

  logic [CTRL_W-1:0]        main_ctrl;
  logic [NWORDS*DATA_W-1:0] main_data;
  logic [RD_W-1:0]          main_rd;
  logic                     main_zero;
  logic [INST_W-1:0]        main_inst;

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = SKID_EN ? in_ready_q : (out_ready | ~out_valid);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: if (in_fire) begin
          state_nxt = ST_BUSY;
          load_main = 1'b1;
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_nxt = ST_FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: if (out_fire) begin
          state_nxt = ST_BUSY;
          load_main = 1'b1;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state so it never depends on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_FULL);
    end
  end

  assign in_pay = {in_ctrl, in_data, in_rd, in_zero, in_inst};
  assign main_d = (state == ST_FULL) ? skid_pay : in_pay;

  pipe_entry #(.W(PAY_W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_main),
    .d     (main_d),
    .q     (main_pay)
  );

  pipe_entry #(.W(PAY_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_skid),
    .d     (in_pay),
    .q     (skid_pay)
  );

  assign {main_ctrl, main_data, main_rd, main_zero, main_inst} = main_pay;

  // Bubbles present a NOP with cleared control; data words keep their last value.
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_rd    = out_valid ? main_rd   : '0;
  assign out_zero  = out_valid & main_zero;
  assign out_inst  = out_valid ? main_inst : NOP_INST;
  assign out_data  = main_data;
  assign occupancy = occupancy_of(state);

endmodule
